interp_seq: RTL and testbench



---
 rtl/interp_seq_if.sv | 46 ++++
 rtl/interp_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_interp_seq.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interp_seq_if.sv
// Bus bundle between interp_seq and its surroundings: vertex input stream,
// external interpolator control/status, and the per-point output stream.
interface interp_seq_if;
    logic        v_stb;
    logic [10:0] v_x;
    logic [10:0] v_y;
    logic        v_last;
    logic        v_ack;

    logic [10:0] i_x1;
    logic [10:0] i_y1;
    logic [10:0] i_x2;
    logic [10:0] i_y2;
    logic        i_load;
    logic        i_ready;
    logic [10:0] i_x;
    logic [10:0] i_y;
    logic        i_finished;
    logic        i_next;

    logic        p_stb;
    logic [10:0] p_x;
    logic [10:0] p_y;
    logic        p_last;
    logic        p_ack;

    // The sequencer sits on the slave side of the vertex stream, but it
    // drives the interpolator controls and the point stream.
    modport slave (
        input  v_stb, v_x, v_y, v_last,
        input  i_ready, i_x, i_y, i_finished,
        input  p_ack,
        output v_ack,
        output i_x1, i_y1, i_x2, i_y2, i_load, i_next,
        output p_stb, p_x, p_y, p_last
    );

    modport master (
        output v_stb, v_x, v_y, v_last,
        output i_ready, i_x, i_y, i_finished,
        output p_ack,
        input  v_ack,
        input  i_x1, i_y1, i_x2, i_y2, i_load, i_next,
        input  p_stb, p_x, p_y, p_last
    );
endinterface

// File: rtl/interp_seq.sv
// Polyline sequencer: walks a vertex stream segment by segment through an
// external interpolator and emits each integer point once on a strobe/ack stream.
module interp_seq (
    input  logic         clk,
    input  logic         rst,
    interp_seq_if.slave  bus,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VERT,
        ST_LOAD,
        ST_WAIT0,
        ST_WAITR,
        ST_SKIP,
        ST_EMIT,
        ST_HOLD
    } state_t;

    state_t      state_q, state_d;

    logic [10:0] prev_x_q, prev_x_d;
    logic [10:0] prev_y_q, prev_y_d;
    logic        first_seg_q, first_seg_d;
    logic        last_seg_q, last_seg_d;
    logic        pt_fin_q, pt_fin_d;

    logic        p_stb_q, p_stb_d;
    logic [10:0] p_x_q, p_x_d;
    logic [10:0] p_y_q, p_y_d;
    logic        p_last_q, p_last_d;

    logic [10:0] i_x1_q, i_x1_d;
    logic [10:0] i_y1_q, i_y1_d;
    logic [10:0] i_x2_q, i_x2_d;
    logic [10:0] i_y2_q, i_y2_d;

    logic        err_q, err_d;

    logic        vert_take;
    logic        vert_ok;
    logic        emit_fire;
    logic        hold_done;

    // Handshake events shared by the next-state and datapath logic.
    assign vert_take = ((state_q == ST_IDLE) || (state_q == ST_VERT)) && bus.v_stb;
    assign vert_ok   = (bus.v_x > prev_x_q);
    assign emit_fire = (state_q == ST_EMIT) && bus.i_ready;
    assign hold_done = (state_q == ST_HOLD) && p_stb_q && bus.p_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.v_stb) begin
                    state_d = ST_HOLD;
                end
            end
            ST_VERT: begin
                if (bus.v_stb) begin
                    if (vert_ok) begin
                        state_d = ST_LOAD;
                    end else if (bus.v_last) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_LOAD:  state_d = ST_WAIT0;
            // The divider ready flag may still reflect the previous segment here.
            ST_WAIT0: state_d = ST_WAITR;
            ST_WAITR: begin
                if (bus.i_ready) begin
                    state_d = ST_SKIP;
                end
            end
            ST_SKIP:  state_d = ST_EMIT;
            ST_EMIT: begin
                if (bus.i_ready) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_done) begin
                    if (p_last_q) begin
                        state_d = ST_IDLE;
                    end else if (pt_fin_q) begin
                        state_d = ST_VERT;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        prev_x_d    = prev_x_q;
        prev_y_d    = prev_y_q;
        first_seg_d = first_seg_q;
        last_seg_d  = last_seg_q;
        pt_fin_d    = pt_fin_q;
        p_stb_d     = p_stb_q;
        p_x_d       = p_x_q;
        p_y_d       = p_y_q;
        p_last_d    = p_last_q;
        i_x1_d      = i_x1_q;
        i_y1_d      = i_y1_q;
        i_x2_d      = i_x2_q;
        i_y2_d      = i_y2_q;
        err_d       = err_q;

        if (vert_take && (state_q == ST_IDLE)) begin
            prev_x_d    = bus.v_x;
            prev_y_d    = bus.v_y;
            p_x_d       = bus.v_x;
            p_y_d       = bus.v_y;
            p_last_d    = bus.v_last;
            p_stb_d     = 1'b1;
            pt_fin_d    = 1'b1;
            first_seg_d = !bus.v_last;
        end

        // A rejected closing vertex still terminates the polyline by re-emitting prev.
        if (vert_take && (state_q == ST_VERT)) begin
            if (vert_ok) begin
                i_x1_d     = prev_x_q;
                i_y1_d     = prev_y_q;
                i_x2_d     = bus.v_x;
                i_y2_d     = bus.v_y;
                prev_x_d   = bus.v_x;
                prev_y_d   = bus.v_y;
                last_seg_d = bus.v_last;
            end else begin
                err_d = 1'b1;
                if (bus.v_last) begin
                    p_x_d    = prev_x_q;
                    p_y_d    = prev_y_q;
                    p_last_d = 1'b1;
                    p_stb_d  = 1'b1;
                    pt_fin_d = 1'b1;
                end
            end
        end

        if (emit_fire) begin
            p_x_d    = bus.i_x;
            p_y_d    = bus.i_y;
            p_stb_d  = 1'b1;
            pt_fin_d = bus.i_finished;
            p_last_d = bus.i_finished && last_seg_q;
            if (bus.i_finished) begin
                first_seg_d = 1'b0;
            end
        end

        if (hold_done) begin
            p_stb_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_x_q    <= '0;
            prev_y_q    <= '0;
            first_seg_q <= 1'b0;
            last_seg_q  <= 1'b0;
            pt_fin_q    <= 1'b0;
            p_stb_q     <= 1'b0;
            p_x_q       <= '0;
            p_y_q       <= '0;
            p_last_q    <= 1'b0;
            i_x1_q      <= '0;
            i_y1_q      <= '0;
            i_x2_q      <= '0;
            i_y2_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            prev_x_q    <= prev_x_d;
            prev_y_q    <= prev_y_d;
            first_seg_q <= first_seg_d;
            last_seg_q  <= last_seg_d;
            pt_fin_q    <= pt_fin_d;
            p_stb_q     <= p_stb_d;
            p_x_q       <= p_x_d;
            p_y_q       <= p_y_d;
            p_last_q    <= p_last_d;
            i_x1_q      <= i_x1_d;
            i_y1_q      <= i_y1_d;
            i_x2_q      <= i_x2_d;
            i_y2_q      <= i_y2_d;
            err_q       <= err_d;
        end
    end

    // SKIP always steps past the segment start, which was already emitted.
    always_comb begin
        bus.v_ack  = vert_take;
        bus.i_load = (state_q == ST_LOAD);
        bus.i_next = (state_q == ST_SKIP) || (emit_fire && !bus.i_finished);
        busy       = (state_q != ST_IDLE) || p_stb_q;
    end

    assign bus.p_stb  = p_stb_q;
    assign bus.p_x    = p_x_q;
    assign bus.p_y    = p_y_q;
    assign bus.p_last = p_last_q;
    assign bus.i_x1   = i_x1_q;
    assign bus.i_y1   = i_y1_q;
    assign bus.i_x2   = i_x2_q;
    assign bus.i_y2   = i_y2_q;
    assign err        = err_q;

    a_next_not_load : assert property (@(posedge clk) disable iff (rst)
        !(bus.i_next && bus.i_load));
    a_next_not_fin : assert property (@(posedge clk) disable iff (rst)
        !(bus.i_next && bus.i_finished));
    a_point_stable : assert property (@(posedge clk) disable iff (rst)
        (p_stb_q && !bus.p_ack) |=> (p_stb_q && $stable({p_x_q, p_y_q, p_last_q})));

endmodule

// File: tb/tb_interp_seq.sv
// Scoreboard bench for interp_seq with a behavioural interpolator model and
// directed polylines whose expected points are written out by hand.
module tb_interp_seq;

    logic clk;
    logic rst;
    logic busy;
    logic err;

    interp_seq_if bus ();

    interp_seq dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        last;
    } pt_t;

    pt_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  load_cnt = 0;
    int  next_cnt = 0;
    bit  stall_mode = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExp(input int x, input int y, input bit last);
        pt_t e;
        e.x = 11'(x);
        e.y = 11'(y);
        e.last = last;
        sb.push_back(e);
    endtask

    // Presents one vertex and holds it until the DUT acknowledges it.
    task automatic applyStimulus(input int x, input int y, input bit last);
        int n = 0;
        bit acked = 1'b0;
        @(posedge clk); #1;
        bus.v_stb  = 1'b1;
        bus.v_x    = 11'(x);
        bus.v_y    = 11'(y);
        bus.v_last = last;
        while (!acked && n < 200) begin
            @(negedge clk);
            acked = bus.v_ack;
            @(posedge clk); #1;
            n++;
        end
        bus.v_stb = 1'b0;
        checkOutput("v_ack_seen", 32'(acked), 32'd1);
    endtask

    task automatic waitIdle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sb.size() != 0) && n < 500);
        checkOutput("idle_reached", 32'(n < 500), 32'd1);
    endtask

    // Interpolator model: 3-cycle divider after load, rounded-half-up y.
    int m_x1 = 0, m_y1 = 0, m_x2 = 0, m_y2 = 0, m_k = 0, m_cnt = 0;
    initial begin
        bit ld, nx;
        int sx1, sy1, sx2, sy2, dx, dy;
        bus.i_ready = 1'b1;
        bus.i_x = '0;
        bus.i_y = '0;
        bus.i_finished = 1'b1;
        forever begin
            @(negedge clk);
            ld  = (bus.i_load === 1'b1);
            nx  = (bus.i_next === 1'b1);
            sx1 = int'(bus.i_x1);
            sy1 = int'(bus.i_y1);
            sx2 = int'(bus.i_x2);
            sy2 = int'(bus.i_y2);
            @(posedge clk); #1;
            if (ld) begin
                m_x1 = sx1; m_y1 = sy1; m_x2 = sx2; m_y2 = sy2;
                m_k = 0;
                m_cnt = 3;
                bus.i_ready = 1'b0;
            end else begin
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) bus.i_ready = 1'b1;
                end
                if (nx) m_k++;
            end
            dx = m_x2 - m_x1;
            dy = m_y2 - m_y1;
            bus.i_x = 11'(m_x1 + m_k);
            if (dx > 0) bus.i_y = 11'(m_y1 + (2 * dy * m_k + dx) / (2 * dx));
            else        bus.i_y = 11'(m_y1);
            bus.i_finished = ((m_x1 + m_k) == m_x2);
        end
    end

    // Consumer: acks at once, or after five stalled cycles per point.
    initial begin
        int cnt = 0;
        bus.p_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!stall_mode) begin
                bus.p_ack = 1'b1;
                cnt = 0;
            end else begin
                if (bus.p_stb) cnt++;
                else cnt = 0;
                bus.p_ack = (cnt > 5);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.i_load === 1'b1) load_cnt++;
                if (bus.i_next === 1'b1) next_cnt++;
                if (bus.p_stb === 1'b1) checkOutput("no_next_while_pstb", 32'(bus.i_next), 32'd0);
            end
        end
    end

    // Monitor: pops the scoreboard on each accepted point, checks holds while stalled.
    initial begin
        pt_t e;
        logic [22:0] held_val;
        bit held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                checkOutput("p_stb_held", 32'(bus.p_stb), 32'd1);
                checkOutput("p_stable", 32'({bus.p_x, bus.p_y, bus.p_last}), 32'(held_val));
            end
            if (bus.p_stb && bus.p_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_point: got (%0d,%0d) expected none", bus.p_x, bus.p_y);
                end else begin
                    e = sb.pop_front();
                    checkOutput("p_x", 32'(bus.p_x), 32'(e.x));
                    checkOutput("p_y", 32'(bus.p_y), 32'(e.y));
                    checkOutput("p_last", 32'(bus.p_last), 32'(e.last));
                end
                held = 1'b0;
            end else if (bus.p_stb) begin
                held = 1'b1;
                held_val = {bus.p_x, bus.p_y, bus.p_last};
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.v_stb = 1'b0;
        bus.v_x = '0;
        bus.v_y = '0;
        bus.v_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_p_stb", 32'(bus.p_stb), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_i_load", 32'(bus.i_load), 32'd0);
        checkOutput("rst_i_next", 32'(bus.i_next), 32'd0);
        checkOutput("rst_p_xy", 32'({bus.p_x, bus.p_y}), 32'd0);
        checkOutput("rst_i_ends", 32'({bus.i_x1, bus.i_x2}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] single segment (0,0)-(4,2)");
        load_cnt = 0; next_cnt = 0;
        pushExp(0, 0, 0); pushExp(1, 1, 0); pushExp(2, 1, 0); pushExp(3, 2, 0); pushExp(4, 2, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(4, 2, 1);
        waitIdle();
        checkOutput("t1_loads", 32'(load_cnt), 32'd1);
        checkOutput("t1_nexts", 32'(next_cnt), 32'd4);

        $display("[TB] two segments (0,0)-(2,2)-(4,2)");
        load_cnt = 0; next_cnt = 0;
        pushExp(0, 0, 0); pushExp(1, 1, 0); pushExp(2, 2, 0); pushExp(3, 2, 0); pushExp(4, 2, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(2, 2, 0);
        applyStimulus(4, 2, 1);
        waitIdle();
        checkOutput("t2_loads", 32'(load_cnt), 32'd2);
        checkOutput("t2_nexts", 32'(next_cnt), 32'd4);
        checkOutput("t2_busy_low", 32'(busy), 32'd0);

        $display("[TB] single vertex (7,9)");
        load_cnt = 0;
        pushExp(7, 9, 1);
        applyStimulus(7, 9, 1);
        waitIdle();
        checkOutput("t3_loads", 32'(load_cnt), 32'd0);

        $display("[TB] non-increasing vertex (5,5),(5,8)");
        load_cnt = 0;
        pushExp(5, 5, 0); pushExp(5, 5, 1);
        applyStimulus(5, 5, 0);
        applyStimulus(5, 8, 1);
        waitIdle();
        checkOutput("t4_err", 32'(err), 32'd1);
        checkOutput("t4_loads", 32'(load_cnt), 32'd0);

        $display("[TB] backpressure (0,0)-(3,3)");
        stall_mode = 1'b1;
        load_cnt = 0; next_cnt = 0;
        pushExp(0, 0, 0); pushExp(1, 1, 0); pushExp(2, 2, 0); pushExp(3, 3, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(3, 3, 1);
        waitIdle();
        checkOutput("t5_loads", 32'(load_cnt), 32'd1);
        checkOutput("t5_nexts", 32'(next_cnt), 32'd3);
        checkOutput("t5_err_sticky", 32'(err), 32'd1);

        $display("[TB] reset during second point");
        pushExp(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(4, 2, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.p_stb && bus.p_x == 11'd1) && n < 100);
        checkOutput("t6_second_point_seen", 32'(n < 100), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        stall_mode = 1'b0;
        @(negedge clk);
        checkOutput("t6_p_stb", 32'(bus.p_stb), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_err", 32'(err), 32'd0);
        checkOutput("t6_sb_drained", 32'(sb.size()), 32'd0);
        load_cnt = 0;
        pushExp(10, 0, 0); pushExp(11, 2, 0); pushExp(12, 4, 1);
        applyStimulus(10, 0, 0);
        applyStimulus(12, 4, 1);
        waitIdle();
        checkOutput("t6_loads", 32'(load_cnt), 32'd1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
